// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the RV32 multi-cycle control FSM:
//   - data/control widths
//   - RV32 opcode and funct3 encodings used by the decoder
//   - ALU operation encodings driven on alu_control
//   - FSM state enum and decoded instruction-class enum
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

    localparam int XLEN       = 32;   // only 32 supported
    localparam int ALU_CTRL_W = 3;

    // opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // funct3
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    // ALU operations
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,   // illegal / treated as NOP
        CLS_R    = 3'd1,
        CLS_I    = 3'd2,
        CLS_LD   = 3'd3,
        CLS_ST   = 3'd4,
        CLS_BR   = 3'd5
    } instr_cls_e;

    // classes that need the MEM state
    function automatic logic is_mem_cls(input instr_cls_e c);
        return (c == CLS_LD) || (c == CLS_ST);
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// ---------------------------------------------------------------------------
// alu_op_decoder
// Purely combinational decode of the held instruction word into the ALU
// operation, the B-operand select, the instruction class and an illegal flag.
// Ports:
//   i_instr       in  XLEN  instruction word from the IR
//   o_alu_control out 3     ALU operation select
//   o_alu_src_b   out 1     0=rs2, 1=immediate
//   o_cls         out enum  decoded instruction class
//   o_illegal     out 1     opcode/funct3 combination not supported
// ---------------------------------------------------------------------------
import mc_ctrl_pkg::*;

module alu_op_decoder (
    input  logic [XLEN-1:0]       i_instr,
    output logic [ALU_CTRL_W-1:0] o_alu_control,
    output logic                  o_alu_src_b,
    output instr_cls_e            o_cls,
    output logic                  o_illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_f7b5;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_f7b5   = i_instr[30];

    // register specifiers and immediates are consumed by the datapath, not here
    logic w_unused;
    assign w_unused = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};

    always_comb begin
        o_alu_control = ALU_ADD;
        o_alu_src_b   = 1'b0;
        o_cls         = CLS_NONE;
        o_illegal     = 1'b0;
        unique case (w_opcode)
            OP_R: begin
                o_cls = CLS_R;
                case (w_funct3)
                    F3_ADD:  o_alu_control = w_f7b5 ? ALU_SUB : ALU_ADD;
                    F3_AND:  o_alu_control = ALU_AND;
                    F3_OR:   o_alu_control = ALU_OR;
                    default: begin
                        o_cls     = CLS_NONE;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            OP_I: begin
                o_cls       = CLS_I;
                o_alu_src_b = 1'b1;
                case (w_funct3)
                    F3_ADD:  o_alu_control = ALU_ADD;
                    F3_AND:  o_alu_control = ALU_AND;
                    F3_OR:   o_alu_control = ALU_OR;
                    default: begin
                        o_cls       = CLS_NONE;
                        o_alu_src_b = 1'b0;
                        o_illegal   = 1'b1;
                    end
                endcase
            end
            OP_LOAD, OP_STORE: begin
                if (w_funct3 == F3_W) begin
                    o_cls         = (w_opcode == OP_LOAD) ? CLS_LD : CLS_ST;
                    o_alu_control = ALU_ADD;   // base + offset
                    o_alu_src_b   = 1'b1;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (w_funct3 == F3_BEQ) begin
                    o_cls         = CLS_BR;
                    o_alu_control = ALU_SUB;   // rs1-rs2, zero means equal
                end else begin
                    o_illegal = 1'b1;
                end
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
// Multi-cycle control FSM for the RV32 core. Sequences
// FETCH/DECODE/EXEC/MEM/WB, drives alu_control and the datapath strobes, and
// resolves beq from the ALU zero flag in EXEC.
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : illegal instruction parks the FSM in TRAP, illegal sticky
//   undefined : illegal instruction is a NOP, illegal pulses for DECODE only
// Ports:
//   i_clk, i_rst_n (sync, active low)
//   i_instr       IR output, stable from DECODE until next ir_write
//   i_mem_ready   memory completes the current request this cycle
//   i_zero        ALU zero flag, used in EXEC only
//   o_alu_control ALU op (000 in IDLE/FETCH/DECODE)
//   o_alu_src_b, o_pc_src, o_pc_write, o_ir_write, o_mem_req, o_mem_we,
//   o_reg_write, o_wb_src, o_illegal
// ---------------------------------------------------------------------------
import mc_ctrl_pkg::*;

module mc_ctrl_fsm (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [XLEN-1:0]       i_instr,
    input  logic                  i_mem_ready,
    input  logic                  i_zero,
    output logic [ALU_CTRL_W-1:0] o_alu_control,
    output logic                  o_alu_src_b,
    output logic                  o_pc_src,
    output logic                  o_pc_write,
    output logic                  o_ir_write,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic                  o_reg_write,
    output logic                  o_wb_src,
    output logic                  o_illegal
);

    state_e                  r_state;
    state_e                  w_state_nxt;

    logic [ALU_CTRL_W-1:0]   r_alu_ctrl;
    logic                    r_alu_src_b;
    instr_cls_e              r_cls;

    logic [ALU_CTRL_W-1:0]   w_dec_alu_ctrl;
    logic                    w_dec_alu_src_b;
    instr_cls_e              w_dec_cls;
    logic                    w_dec_illegal;

    alu_op_decoder u_dec (
        .i_instr       (i_instr),
        .o_alu_control (w_dec_alu_ctrl),
        .o_alu_src_b   (w_dec_alu_src_b),
        .o_cls         (w_dec_cls),
        .o_illegal     (w_dec_illegal)
    );

    // state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // decode fields captured at the end of DECODE, held through EXEC/MEM/WB
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_alu_ctrl  <= ALU_ADD;
            r_alu_src_b <= 1'b0;
            r_cls       <= CLS_NONE;
        end else if (r_state == ST_DECODE) begin
            r_alu_ctrl  <= w_dec_alu_ctrl;
            r_alu_src_b <= w_dec_alu_src_b;
            r_cls       <= w_dec_cls;
        end
    end

    // next state and outputs
    always_comb begin
        w_state_nxt   = r_state;
        o_alu_control = ALU_ADD;
        o_alu_src_b   = 1'b0;
        o_pc_src      = 1'b0;
        o_pc_write    = 1'b0;
        o_ir_write    = 1'b0;
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        o_reg_write   = 1'b0;
        o_wb_src      = 1'b0;
        o_illegal     = 1'b0;

        unique case (r_state)
            ST_IDLE: w_state_nxt = ST_FETCH;

            ST_FETCH: begin
                o_mem_req = 1'b1;
                // IR and PC+4 load in the cycle memory returns the word
                if (i_mem_ready) begin
                    o_ir_write  = 1'b1;
                    o_pc_write  = 1'b1;
                    w_state_nxt = ST_DECODE;
                end
            end

            ST_DECODE: begin
                o_illegal = w_dec_illegal;
                if (w_dec_illegal) begin
`ifdef ILLEGAL_TRAP_EN
                    w_state_nxt = ST_TRAP;
`else
                    w_state_nxt = ST_FETCH;
`endif
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end

            ST_EXEC: begin
                o_alu_control = r_alu_ctrl;
                o_alu_src_b   = r_alu_src_b;
                if (r_cls == CLS_BR) begin
                    // PC already holds PC+4; only load the target when taken
                    o_pc_src    = 1'b1;
                    o_pc_write  = i_zero;
                    w_state_nxt = ST_FETCH;
                end else if (is_mem_cls(r_cls)) begin
                    w_state_nxt = ST_MEM;
                end else begin
                    w_state_nxt = ST_WB;
                end
            end

            ST_MEM: begin
                o_alu_control = r_alu_ctrl;
                o_alu_src_b   = r_alu_src_b;
                o_mem_req     = 1'b1;
                o_mem_we      = (r_cls == CLS_ST);
                if (i_mem_ready)
                    w_state_nxt = (r_cls == CLS_ST) ? ST_FETCH : ST_WB;
            end

            ST_WB: begin
                o_alu_control = r_alu_ctrl;
                o_alu_src_b   = r_alu_src_b;
                o_reg_write   = 1'b1;
                o_wb_src      = (r_cls == CLS_LD);
                w_state_nxt   = ST_FETCH;
            end

            ST_TRAP: begin
                o_illegal   = 1'b1;   // held until reset
                w_state_nxt = ST_TRAP;
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
